// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Collects WIDTH accepted serial bits into a parallel word. A frame begins
//   with an accepted bit that carries sof; the WIDTH-th accepted bit of the
//   frame completes the word. The word is then offered on a valid/ready port.
//   Two sticky flags are raised:
//     overrun   - a completed word was dropped because the output was still full
//     short_err - sof arrived while a partial word was pending
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      asynchronous active-high reset
//   din        in   1      serial data bit
//   din_valid  in   1      din/sof are sampled only when 1
//   sof        in   1      this accepted bit is bit 0 of a new word
//   out_data   out  WIDTH  assembled word, stable while out_valid=1
//   out_valid  out  1      word available
//   out_ready  in   1      consumer accepts (transfer = out_valid & out_ready)
//   overrun    out  1      sticky overrun flag
//   short_err  out  1      sticky short-frame flag
//   clr_flags  in   1      synchronous clear of overrun and short_err
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             short_err,
    input  logic             clr_flags
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [WIDTH-1:0] shifted_s;
    logic             done_s;
    logic             short_set_s;
    logic             ovr_set_s;

    logic [WIDTH-1:0] data_r, data_s;
    logic             valid_r, valid_s;
    logic             ovr_r, ovr_s;
    logic             short_r, short_s;

    // Shift register contents after shifting in the current din.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shift_r[WIDTH-2:0], din};
        end else begin
            shifted_s = {din, shift_r[WIDTH-1:1]};
        end
    end

    // Frame FSM: next state, bit counter and shift register.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shift_s     = shift_r;
        done_s      = 1'b0;
        short_set_s = 1'b0;
        if (din_valid) begin
            case (state_r)
                IDLE: begin
                    if (sof) begin
                        shift_s = shifted_s;
                        cnt_s   = CNT_ONE;
                        state_s = SHIFT;
                    end else begin
                        state_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (sof) begin
                        // a partial word is always pending in SHIFT; restart on this bit
                        shift_s     = shifted_s;
                        cnt_s       = CNT_ONE;
                        short_set_s = 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        shift_s = shifted_s;
                        cnt_s   = CNT_ZERO;
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        shift_s = shifted_s;
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output handshake and sticky flags; a set event beats clr_flags.
    always_comb begin
        data_s    = data_r;
        valid_s   = valid_r;
        ovr_set_s = 1'b0;
        if (done_s) begin
            if (!valid_r || out_ready) begin
                // shifted_s already holds the completing bit
                data_s  = shifted_s;
                valid_s = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (valid_r && out_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        if (ovr_set_s) begin
            ovr_s = 1'b1;
        end else if (clr_flags) begin
            ovr_s = 1'b0;
        end else begin
            ovr_s = ovr_r;
        end

        if (short_set_s) begin
            short_s = 1'b1;
        end else if (clr_flags) begin
            short_s = 1'b0;
        end else begin
            short_s = short_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            shift_r <= {WIDTH{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
            short_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            ovr_r   <= ovr_s;
            short_r <= short_s;
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign overrun   = ovr_r;
    assign short_err = short_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
//   Drives one shared random/directed bit stream into two deserializers
//   (MSB-first and LSB-first, WIDTH=8) and compares both against a
//   frame-level model built from a queue of received bits.
module tb_sipo_deserializer;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic       out_ready;
    logic       clr_flags;

    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ovr0, ovr1;
    logic       short0, short1;

    int checks   = 0;
    int failures = 0;

    // model state: index 0 = MSB-first instance, 1 = LSB-first instance
    bit         frame_q[$];
    bit         in_frame;
    logic [7:0] m_data[2];
    logic       m_valid;
    logic       m_ovr;
    logic       m_short;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .out_data(data0), .out_valid(valid0), .out_ready(out_ready),
        .overrun(ovr0), .short_err(short0), .clr_flags(clr_flags)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .out_data(data1), .out_valid(valid1), .out_ready(out_ready),
        .overrun(ovr1), .short_err(short1), .clr_flags(clr_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        in_frame  = 1'b0;
        m_data[0] = 8'h00;
        m_data[1] = 8'h00;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        m_short   = 1'b0;
    endtask

    // One clock edge of the model, using the inputs the DUT just sampled.
    task automatic model_step();
        bit         done = 1'b0;
        bit         short_set = 1'b0;
        bit         ovr_set = 1'b0;
        logic [7:0] w_msb = 8'h00;
        logic [7:0] w_lsb = 8'h00;
        if (din_valid) begin
            if (sof) begin
                if (in_frame) short_set = 1'b1;
                frame_q.delete();
                frame_q.push_back(din);
                in_frame = 1'b1;
            end else if (in_frame) begin
                frame_q.push_back(din);
                if (frame_q.size() == 8) begin
                    for (int i = 0; i < 8; i++) begin
                        w_msb[7-i] = frame_q[i];
                        w_lsb[i]   = frame_q[i];
                    end
                    done = 1'b1;
                    frame_q.delete();
                    in_frame = 1'b0;
                end
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                m_data[0] = w_msb;
                m_data[1] = w_lsb;
                m_valid   = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        m_ovr   = ovr_set   ? 1'b1 : (clr_flags ? 1'b0 : m_ovr);
        m_short = short_set ? 1'b1 : (clr_flags ? 1'b0 : m_short);
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    // Send word w as 8 bits, w[7] first, sof on the first; gap idle cycles between bits.
    task automatic send_bits(input logic [7:0] w, input int gap, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            din       = w[i];
            din_valid = 1'b1;
            sof       = (i == 7);
            if (i == 0) out_ready = rdy_last;
            cyc();
            din_valid = 1'b0;
            sof       = 1'b0;
            if (i > 0) repeat (gap) cyc();
        end
    endtask

    task automatic mid_cycle_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_data0", {24'h0, data0}, 32'h0);
        chk("rst_async_data1", {24'h0, data1}, 32'h0);
        chk("rst_async_flags", {28'h0, valid0, valid1, ovr0 | ovr1, short0 | short1}, 32'h0);
        cyc();
        rst = 1'b0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_data_msb", {24'h0, data0}, {24'h0, m_data[0]});
            chk("cyc_data_lsb", {24'h0, data1}, {24'h0, m_data[1]});
            chk("cyc_valid", {30'h0, valid0, valid1}, {30'h0, m_valid, m_valid});
            chk("cyc_overrun", {30'h0, ovr0, ovr1}, {30'h0, m_ovr, m_ovr});
            chk("cyc_short", {30'h0, short0, short1}, {30'h0, m_short, m_short});
        end
    end

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
        out_ready = 1'b1; clr_flags = 1'b0;
        model_reset();
        #1;
        chk("reset_data", {16'h0, data0, data1}, 32'h0);
        chk("reset_flags", {28'h0, valid0, valid1, ovr0, short0}, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // 1. basic word back to back
        send_bits(8'hA5, 0, 1'b1);
        chk("t1_data_msb", {24'h0, data0}, 32'hA5);
        chk("t1_data_lsb", {24'h0, data1}, 32'hA5);
        chk("t1_model", {24'h0, m_data[0]}, 32'hA5);
        chk("t1_valid", {31'h0, valid0}, 32'h1);
        cyc();
        chk("t1_valid_drop", {31'h0, valid0}, 32'h0);

        // 2. gaps of 3 cycles
        send_bits(8'hA5, 3, 1'b1);
        chk("t2_data", {24'h0, data0}, 32'hA5);
        chk("t2_valid", {31'h0, valid0}, 32'h1);
        cyc();

        // 3. backpressure
        out_ready = 1'b0;
        send_bits(8'hA5, 0, 1'b0);
        send_bits(8'h3C, 0, 1'b0);
        chk("t3_data_held", {24'h0, data0}, 32'hA5);
        chk("t3_valid_held", {31'h0, valid0}, 32'h1);
        chk("t3_overrun", {31'h0, ovr0}, 32'h1);
        chk("t3_model_ovr", {31'h0, m_ovr}, 32'h1);
        out_ready = 1'b1;
        cyc();
        chk("t3_drain", {31'h0, valid0}, 32'h0);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("t3_clr", {31'h0, ovr0}, 32'h0);

        // 4. short frame: 3 partial bits then a full 8'h81
        din_valid = 1'b1;
        din = 1'b1; sof = 1'b1; cyc();
        din = 1'b0; sof = 1'b0; cyc();
        din = 1'b1; cyc();
        din_valid = 1'b0;
        chk("t4_no_word", {31'h0, valid0}, 32'h0);
        send_bits(8'h81, 0, 1'b1);
        chk("t4_short", {31'h0, short0}, 32'h1);
        chk("t4_data_msb", {24'h0, data0}, 32'h81);
        chk("t4_data_lsb", {24'h0, data1}, 32'h81);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("t4_clr", {31'h0, short0}, 32'h0);

        // 5. second completion while the first word is still pending and being taken
        out_ready = 1'b0;
        send_bits(8'h12, 0, 1'b0);
        chk("t5_first", {24'h0, data0}, 32'h12);
        send_bits(8'h34, 0, 1'b1);
        chk("t5_second", {24'h0, data0}, 32'h34);
        chk("t5_valid_kept", {31'h0, valid0}, 32'h1);
        chk("t5_no_overrun", {31'h0, ovr0}, 32'h0);
        cyc();
        chk("t5_drained", {31'h0, valid0}, 32'h0);

        // 6. reset mid-word, then a clean frame
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 1'(i & 1);
            sof = (i == 0);
            cyc();
        end
        din_valid = 1'b0; sof = 1'b0;
        mid_cycle_reset();
        send_bits(8'hC3, 0, 1'b1);
        chk("t6_data", {24'h0, data0}, 32'hC3);
        chk("t6_short", {31'h0, short0}, 32'h0);
        cyc();

        // LSB-first ordering: bits 1,1,0,0,0,0,0,0
        send_bits(8'hC0, 0, 1'b1);
        chk("lsb_data", {24'h0, data1}, 32'h03);
        chk("lsb_msb_inst", {24'h0, data0}, 32'hC0);
        chk("lsb_model", {24'h0, m_data[1]}, 32'h03);
        cyc();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din       = 1'($urandom_range(0, 1));
            sof       = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_flags = ($urandom_range(0, 15) == 0);
            cyc();
            if (n == 1500) mid_cycle_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
